// File: rtl/sha1_schedule_source_if.sv
// Block-in / word-out handshake bundle for the SHA-1 schedule source.
// master drives blocks and accepts words; slave is the schedule source.
interface sha1_schedule_source_if;
   logic [511:0] blk_in;
   logic         blk_valid;
   logic         blk_ready;
   logic [31:0]  out_word;
   logic [6:0]   out_index;
   logic         out_last;
   logic         out_valid;
   logic         out_ready;

   modport master (
      output blk_in, blk_valid, out_ready,
      input  blk_ready, out_word, out_index, out_last, out_valid
   );

   modport slave (
      input  blk_in, blk_valid, out_ready,
      output blk_ready, out_word, out_index, out_last, out_valid
   );
endinterface

// File: rtl/sha1_schedule_source.sv
// SHA-1 message expansion: streams W[t] (optionally +K[t]) for t=0..79
// from a 16-word sliding window, one word per accepted beat.
module sha1_schedule_source #(
   parameter bit ADD_K = 1'b1
) (
   input logic clk,
   input logic rst_n,
   sha1_schedule_source_if.slave bus
);
   typedef enum logic {IDLE, RUN} state_t;

   state_t      state;
   logic [31:0] w [16];
   logic [6:0]  t;
   logic        fire;
   logic        last_fire;
   logic        load;
   logic [31:0] k;
   logic [31:0] mix;
   logic [31:0] w_next;

   always_comb begin
      k = 32'hCA62C1D6;
      if (t < 7'd20)
         k = 32'h5A827999;
      else if (t < 7'd40)
         k = 32'h6ED9EBA1;
      else if (t < 7'd60)
         k = 32'h8F1BBCDC;
   end

   assign mix    = w[13] ^ w[8] ^ w[2] ^ w[0];
   assign w_next = {mix[30:0], mix[31]};

   assign fire      = (state == RUN) && bus.out_ready;
   assign last_fire = fire && (t == 7'd79);
   // reload is only possible on the beat that retires round 79
   assign bus.blk_ready = (state == IDLE) || last_fire;
   assign load          = bus.blk_valid && bus.blk_ready;

   assign bus.out_valid = (state == RUN);
   assign bus.out_index = t;
   assign bus.out_last  = (t == 7'd79);
   assign bus.out_word  = ADD_K ? (w[0] + k) : w[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         t     <= '0;
         for (int i = 0; i < 16; i++)
            w[i] <= '0;
      end else if (load) begin
         state <= RUN;
         t     <= '0;
         for (int i = 0; i < 16; i++)
            w[i] <= bus.blk_in[511-32*i -: 32];
      end else if (fire) begin
         for (int i = 0; i < 15; i++)
            w[i] <= w[i+1];
         w[15] <= w_next;
         if (last_fire) begin
            state <= IDLE;
            t     <= '0;
         end else begin
            t <= t + 7'd1;
         end
      end
   end
endmodule

// File: tb/tb_sha1_schedule_source.sv
// Directed-plus-random bench for sha1_schedule_source, both ADD_K settings
// side by side, against a plain-arithmetic SHA-1 schedule model.
module tb_sha1_schedule_source;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sha1_schedule_source_if b1 ();
   sha1_schedule_source_if b0 ();

   assign b0.blk_in    = b1.blk_in;
   assign b0.blk_valid = b1.blk_valid;
   assign b0.out_ready = b1.out_ready;

   sha1_schedule_source #(.ADD_K(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(b1.slave)
   );
   sha1_schedule_source #(.ADD_K(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(b0.slave)
   );

   localparam logic [511:0] ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_w [80];
   int          et = 0;
   bit          busy = 1'b0;
   bit          cur_abc = 1'b0;
   bit          accepted = 1'b0;
   logic [511:0] q [$];

   function automatic logic [31:0] kof(input int n);
      if (n < 20) return 32'h5A827999;
      if (n < 40) return 32'h6ED9EBA1;
      if (n < 60) return 32'h8F1BBCDC;
      return 32'hCA62C1D6;
   endfunction

   task automatic load_model(input logic [511:0] b);
      logic [31:0] x;
      for (int i = 0; i < 16; i++) exp_w[i] = b[511-32*i -: 32];
      for (int i = 16; i < 80; i++) begin
         x = exp_w[i-3] ^ exp_w[i-8] ^ exp_w[i-14] ^ exp_w[i-16];
         exp_w[i] = {x[30:0], x[31]};
      end
   endtask

   function automatic logic [511:0] rand_blk();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
      return b;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // known published values for the "abc" block
   task automatic golden(input int n);
      logic [31:0] g1, g0;
      bit have1, have0;
      have1 = 1'b1; have0 = 1'b0; g0 = '0;
      case (n)
         0:  begin g1 = 32'hBBE4DD19; g0 = 32'h61626380; have0 = 1'b1; end
         15: g1 = 32'h5A8279B1;
         16: begin g1 = 32'h1D474099; g0 = 32'hC2C4C700; have0 = 1'b1; end
         17: g1 = 32'h5A827999;
         18: begin g1 = 32'h5A8279C9; g0 = 32'h00000030; have0 = 1'b1; end
         default: begin g1 = '0; have1 = 1'b0; end
      endcase
      if (have1) chk($sformatf("abc_k_t%0d", n), b1.out_word, g1);
      if (have0) chk($sformatf("abc_raw_t%0d", n), b0.out_word, g0);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_valid1"}, b1.out_valid, 0);
      chk({tag, "_valid0"}, b0.out_valid, 0);
      chk({tag, "_bready1"}, b1.blk_ready, 1);
      chk({tag, "_bready0"}, b0.blk_ready, 1);
      chk({tag, "_index"}, b1.out_index, 0);
      chk({tag, "_last"}, b1.out_last, 0);
      chk({tag, "_word1"}, b1.out_word, 32'h5A827999);
      chk({tag, "_word0"}, b0.out_word, 0);
   endtask

   task automatic cyc(input bit bv, input logic [511:0] bd, input int lowpct);
      bit rdy_m;
      @(negedge clk);
      b1.blk_valid = bv;
      b1.blk_in    = bd;
      b1.out_ready = ($urandom_range(99) >= lowpct);
      #1;
      accepted = 1'b0;
      rdy_m = !busy || (b1.out_ready && et == 79);
      chk("out_valid1", b1.out_valid, busy);
      chk("out_valid0", b0.out_valid, busy);
      chk("blk_ready1", b1.blk_ready, rdy_m);
      chk("blk_ready0", b0.blk_ready, rdy_m);
      if (busy) begin
         chk($sformatf("word1_t%0d", et), b1.out_word, exp_w[et] + kof(et));
         chk($sformatf("word0_t%0d", et), b0.out_word, exp_w[et]);
         chk("index1", b1.out_index, et);
         chk("index0", b0.out_index, et);
         chk("last1", b1.out_last, et == 79);
         chk("last0", b0.out_last, et == 79);
         if (cur_abc) golden(et);
      end
      if (busy && b1.out_ready) begin
         if (et == 79) busy = 1'b0;
         else et++;
      end
      if (bv && rdy_m) begin
         load_model(bd);
         et = 0;
         busy = 1'b1;
         cur_abc = (bd == ABC);
         accepted = 1'b1;
      end
   endtask

   initial begin
      logic [511:0] r;
      int n;
      b1.blk_valid = 1'b0;
      b1.blk_in    = '0;
      b1.out_ready = 1'b0;
      #12;
      reset_checks("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // abc block, full throughput
      cyc(1'b1, ABC, 0);
      for (int i = 0; i < 82; i++) cyc(1'b0, '0, 0);

      // random block, crosses every K boundary
      cyc(1'b1, rand_blk(), 0);
      for (int i = 0; i < 82; i++) cyc(1'b0, '0, 0);

      // abc under random backpressure
      cyc(1'b1, ABC, 0);
      n = 0;
      while (busy && n < 600) begin
         cyc(1'b0, '0, 40);
         n++;
      end
      chk("bp_done", busy, 0);

      // two blocks back to back, blk_valid held high
      q.push_back(rand_blk());
      q.push_back(ABC);
      n = 0;
      while ((q.size() > 0 || busy) && n < 300) begin
         if (q.size() > 0) cyc(1'b1, q[0], 0);
         else cyc(1'b0, '0, 0);
         if (accepted) void'(q.pop_front());
         n++;
      end
      chk("b2b_done", busy, 0);

      // stray blk_valid pulses mid-stream are ignored
      cyc(1'b1, rand_blk(), 0);
      r = rand_blk();
      for (int i = 0; i < 82; i++) cyc(busy && et >= 10 && et <= 14, r, 10);
      n = 0;
      while (busy && n < 100) begin
         cyc(1'b0, '0, 0);
         n++;
      end
      chk("stray_done", busy, 0);

      // asynchronous reset in the middle of round 37
      cyc(1'b1, rand_blk(), 0);
      n = 0;
      while (!(busy && et == 37) && n < 200) begin
         cyc(1'b0, '0, 0);
         n++;
      end
      chk("reach_t37", et, 37);
      @(posedge clk);
      #2;
      chk("pre_rst_index", b1.out_index, 37);
      rst_n = 1'b0;
      #1;
      reset_checks("midrst");
      busy = 1'b0;
      et = 0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b0, '0, 0);
      cyc(1'b1, ABC, 0);
      for (int i = 0; i < 82; i++) cyc(1'b0, '0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sha1_schedule_source.md
Name: sha1_schedule_source

Overview:
- Producer side of the per-round P word consumed by the SHA-1 round pipeline.
- Accepts one 512-bit message block over a valid/ready handshake.
- Emits the 80 scheduled words W[t] (optionally pre-added with K[t]) as a stream, one word per accepted beat, with round index and last flag.
- The round engine adds E[t] downstream. This block owns only message expansion and constant injection.

Parameters:
- ADD_K, 1: 1 = out_word is W[t]+K[t] mod 2^32; 0 = out_word is raw W[t].

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- blk_in  in  512  message block; word M0 in [511:480], M15 in [31:0], big-endian words.
- blk_valid  in  1  blk_in valid.
- blk_ready  out  1  block accept.
- out_word  out  32  W[t] or W[t]+K[t].
- out_index  out  7  round t, 0..79.
- out_last  out  1  high when out_index==79.
- out_valid  out  1  out_word valid.
- out_ready  in  1  consumer accepts the word.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, t=0, window cleared to 0.
  - out_valid=0, blk_ready=1, out_index=0, out_last=0, out_word=K[0] if ADD_K else 0.
  - Reset mid-block abandons the block; no further words are emitted.
- State is held in a 16x32 window w[0..15] holding W[t..t+15], plus a 7-bit counter t.
- IDLE:
  - blk_ready=1, out_valid=0.
  - On blk_valid&blk_ready: w[i]<=M[i], t<=0, go RUN.
- RUN:
  - out_valid=1, out_word = w[0] (+K(t) if ADD_K), out_index=t, out_last=(t==79).
  - Beat fires on out_valid&out_ready. Then w[i]<=w[i+1] for i<15, w[15]<=rotl1(w[13]^w[8]^w[2]^w[0]), t<=t+1.
  - out_ready low: all outputs and state hold, stable until accepted.
- Constants:
  - K = 5A827999 for t 0-19, 6ED9EBA1 for 20-39, 8F1BBCDC for 40-59, CA62C1D6 for 60-79.
  - K is selected from t by comparison only, no ROM. Addition is 32-bit, carry discarded.
- Last beat (t==79 fires):
  - blk_ready=1 in that same cycle, combinational from state, t and out_ready.
  - If blk_valid is also high: load the new block, t<=0, stay RUN. The next cycle emits new t=0 with no bubble.
  - Otherwise go IDLE.
- blk_ready is 0 in RUN except on a firing last beat. blk_valid while not ready is ignored, and blk_in is not sampled.
- Latency: block accepted in cycle N -> out_valid=1 with out_index=0 in N+1. Full throughput is 80 words per 80 cycles.
- No combinational path from blk_in to out_*. out_word is driven from registers through one 32-bit adder. blk_ready depends combinationally on out_ready.
- Word rotation (rotl1) is a fixed 1-bit left rotate on 32 bits. t never exceeds 79; wrap occurs only via reload or IDLE.

Test Plan:
1. SHA-1("abc") padded block (W0=61626380, W1..W14=0, W15=00000018), ADD_K=1, out_ready=1 -> exactly 80 beats with out_index 0..79 and out_last only at 79:
   - t0=BBE4DD19, t15=5A8279B1, t16=1D474099 (W16=C2C4C700), t17=5A827999, t18=5A8279C9.
   - t19..t79 match a software SHA-1 schedule model.
2. Same block with ADD_K=0 -> t0=61626380, t16=C2C4C700, t18=00000030. K boundary checked on a nonzero block at t19/20, 39/40 and 59/60.
3. Random out_ready backpressure (~40% low) -> word sequence identical to case 1. out_word, out_index and out_valid stay stable while out_ready=0.
4. blk_valid held high with two blocks queued -> second block's t=0 appears in the cycle after the first block's t=79 fires, with no bubble. blk_ready pulses only on that cycle.
5. rst_n asserted asynchronously at t=37 mid-clock -> out_valid drops immediately, blk_ready=1. A fresh block afterwards produces the correct full 80-word stream.
6. blk_valid pulsed during RUN (not the last beat) -> ignored. The stream continues unchanged, and the block is not loaded.
